// File: rtl/inst_fetch.sv
// Switch-based instruction fetch: debounces a step pushbutton and, on each accepted
// press, emits a one-cycle strobe carrying the registered switch word and a press count.
module inst_fetch #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btnS,
  output logic       inst_vld,
  output logic [7:0] inst_wd,
  output logic [7:0] inst_cnt,
  output logic       busy
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, btn_s_q;
  logic [7:0]    sw_q;
  logic          inst_vld_q, inst_vld_d;
  logic [7:0]    inst_wd_q, inst_wd_d;
  logic [7:0]    inst_cnt_q, inst_cnt_d;
  logic          busy_q, busy_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_q       <= 8'h00;
      state_q    <= IDLE;
      cnt_q      <= '0;
      inst_vld_q <= 1'b0;
      inst_wd_q  <= 8'h00;
      inst_cnt_q <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= btnS;
      btn_s_q    <= sync1_q;
      sw_q       <= sw;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_vld_q <= inst_vld_d;
      inst_wd_q  <= inst_wd_d;
      inst_cnt_q <= inst_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_vld_d = 1'b0;
    inst_wd_d  = inst_wd_q;
    inst_cnt_d = inst_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = PRESSED;
          inst_vld_d = 1'b1;
          inst_wd_d  = sw_q;
          inst_cnt_d = inst_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        // A bounce back high re-enters PRESSED without a strobe.
        if (btn_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign inst_vld = inst_vld_q;
  assign inst_wd  = inst_wd_q;
  assign inst_cnt = inst_cnt_q;
  assign busy     = busy_q;

endmodule
